// File: rtl/minibyte_bus_arbiter.sv
// rtl/minibyte_bus_arbiter.sv - two-port round-robin arbiter for the shared minibyte memory/IO bus
// Fixed-length bus cycles with registered outputs, one-cycle acks and a turnaround cycle after writes.
module minibyte_bus_arbiter #(
    parameter int ADDR_W        = 7,
    parameter int DATA_W        = 8,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    input  logic [DATA_W-1:0] data_in,
    output logic [ADDR_W-1:0] addr_out,
    output logic [DATA_W-1:0] data_out,
    output logic              we_out,
    output logic              drive_out,
    output logic [1:0]        grant_out
);

    localparam int CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ACCESS_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, TURN} state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              port_q, port_d;
    logic              we_q, we_d;
    logic              last_grant_q, last_grant_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              we_out_q, we_out_d;
    logic              drive_out_q, drive_out_d;
    logic [1:0]        grant_q, grant_d;
    logic              m0_ack_q, m0_ack_d;
    logic              m1_ack_q, m1_ack_d;
    logic [DATA_W-1:0] m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0] m1_rdata_q, m1_rdata_d;
    logic              sel;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        port_d       = port_q;
        we_d         = we_q;
        last_grant_d = last_grant_q;
        addr_d       = addr_q;
        data_out_d   = data_out_q;
        we_out_d     = we_out_q;
        drive_out_d  = drive_out_q;
        grant_d      = grant_q;
        m0_ack_d     = 1'b0;
        m1_ack_d     = 1'b0;
        m0_rdata_d   = '0;
        m1_rdata_d   = '0;
        // On a tie the port that did not win last time takes the bus.
        sel          = (m0_req && m1_req) ? ~last_grant_q : m1_req;

        case (state_q)
            IDLE: begin
                if (m0_req || m1_req) begin
                    port_d      = sel;
                    we_d        = sel ? m1_we : m0_we;
                    addr_d      = sel ? m1_addr : m0_addr;
                    data_out_d  = we_d ? (sel ? m1_wdata : m0_wdata) : '0;
                    we_out_d    = we_d;
                    drive_out_d = we_d;
                    grant_d     = sel ? 2'b10 : 2'b01;
                    cnt_d       = CNT_LOAD;
                    state_d     = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_d     = DONE;
                    we_out_d    = 1'b0;
                    drive_out_d = 1'b0;
                    data_out_d  = '0;
                    if (port_q) begin
                        m1_ack_d   = 1'b1;
                        m1_rdata_d = we_q ? '0 : data_in;
                    end else begin
                        m0_ack_d   = 1'b1;
                        m0_rdata_d = we_q ? '0 : data_in;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                last_grant_d = port_q;
                addr_d       = '0;
                data_out_d   = '0;
                we_out_d     = 1'b0;
                drive_out_d  = 1'b0;
                grant_d      = 2'b00;
                state_d      = we_q ? TURN : IDLE;
            end
            TURN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            port_q       <= 1'b0;
            we_q         <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            data_out_q   <= '0;
            we_out_q     <= 1'b0;
            drive_out_q  <= 1'b0;
            grant_q      <= 2'b00;
            m0_ack_q     <= 1'b0;
            m1_ack_q     <= 1'b0;
            m0_rdata_q   <= '0;
            m1_rdata_q   <= '0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            port_q       <= port_d;
            we_q         <= we_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            data_out_q   <= data_out_d;
            we_out_q     <= we_out_d;
            drive_out_q  <= drive_out_d;
            grant_q      <= grant_d;
            m0_ack_q     <= m0_ack_d;
            m1_ack_q     <= m1_ack_d;
            m0_rdata_q   <= m0_rdata_d;
            m1_rdata_q   <= m1_rdata_d;
        end
    end

    assign addr_out  = addr_q;
    assign data_out  = data_out_q;
    assign we_out    = we_out_q;
    assign drive_out = drive_out_q;
    assign grant_out = grant_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;

endmodule

// File: tb/tb_minibyte_bus_arbiter.sv
// tb/tb_minibyte_bus_arbiter.sv - randomized scoreboard bench for minibyte_bus_arbiter
// Three instances (ACCESS_CYCLES = 2, 1, 15) each with a driver, a bus slave and a monitor.
module tb_minibyte_bus_arbiter;

    typedef struct packed {
        logic       we;
        logic [6:0] addr;
        logic [7:0] wdata;
    } txn_t;

    localparam int NTX   = 20;
    localparam int LIMIT = 4000;

    logic clk = 1'b0;
    initial forever #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    bit bdone [3];

    task automatic chk(input int g, input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL g%0d %s: got 0x%0h expected 0x%0h", g, name, act, exp);
        end
    endtask

    for (genvar gi = 0; gi < 3; gi++) begin : g
        localparam int AC = (gi == 0) ? 2 : ((gi == 1) ? 1 : 15);

        logic       rst;
        logic [1:0] req, we, ack, samp_req;
        logic [6:0] addr [2];
        logic [7:0] wdata [2];
        logic [7:0] rdata [2];
        logic [7:0] data_in, data_out;
        logic [6:0] addr_out;
        logic       we_out, drive_out, mon_en;
        logic [1:0] grant_out;
        txn_t       expq [2][$];
        int         cyc;

        minibyte_bus_arbiter #(.ADDR_W(7), .DATA_W(8), .ACCESS_CYCLES(AC)) dut (
            .clk_in(clk), .rst_in(rst),
            .m0_req(req[0]), .m0_we(we[0]), .m0_addr(addr[0]), .m0_wdata(wdata[0]),
            .m0_ack(ack[0]), .m0_rdata(rdata[0]),
            .m1_req(req[1]), .m1_we(we[1]), .m1_addr(addr[1]), .m1_wdata(wdata[1]),
            .m1_ack(ack[1]), .m1_rdata(rdata[1]),
            .data_in(data_in), .addr_out(addr_out), .data_out(data_out),
            .we_out(we_out), .drive_out(drive_out), .grant_out(grant_out)
        );

        // Bus slave: read data depends on the address and changes every other cycle.
        initial begin
            cyc = 0;
            data_in = 8'h00;
            forever begin
                @(posedge clk);
                #1;
                cyc++;
                data_in = 8'(int'(addr_out) * 37) ^ 8'(cyc >> 1);
            end
        end

        initial forever begin
            @(posedge clk);
            samp_req = req;
        end

        initial begin : drv
            logic busy [2];
            int   issued [2];
            bit   scr [2];
            int   c;
            txn_t t;
            rst = 1'b1;
            mon_en = 1'b0;
            for (int p = 0; p < 2; p++) begin
                req[p] = 1'b0; we[p] = 1'b0; addr[p] = '0; wdata[p] = '0;
                busy[p] = 1'b0; issued[p] = 0; scr[p] = 1'b0;
            end
            repeat (2) @(negedge clk);
            chk(gi, "reset_ctrl", {ack, grant_out, we_out, drive_out}, 0);
            chk(gi, "reset_data", {rdata[0], rdata[1], addr_out, data_out}, 0);
            rst = 1'b0;

            // Abort a write with reset while it is on the bus.
            @(negedge clk);
            req[0] = 1'b1; we[0] = 1'b1; addr[0] = 7'h2A; wdata[0] = 8'h99;
            c = 0;
            while (grant_out != 2'b01 && c < 20) begin
                @(negedge clk);
                c++;
            end
            chk(gi, "abort_granted", {grant_out, we_out, drive_out, data_out}, {2'b01, 2'b11, 8'h99});
            #1 rst = 1'b1;
            #1;
            chk(gi, "abort_outputs", {ack, we_out, drive_out, grant_out, addr_out, data_out}, 0);
            req[0] = 1'b0; we[0] = 1'b0;
            repeat (2) @(negedge clk);
            rst = 1'b0;
            c = 0;
            repeat (6) begin
                @(negedge clk);
                if (ack != 2'b00 || grant_out != 2'b00) c++;
            end
            chk(gi, "abort_no_ack", c, 0);

            mon_en = 1'b1;
            for (c = 0; c < LIMIT; c++) begin
                if (issued[0] >= NTX && issued[1] >= NTX && !busy[0] && !busy[1]) break;
                @(negedge clk);
                for (int p = 0; p < 2; p++) begin
                    if (busy[p] && ack[p]) busy[p] = 1'b0;
                    if (!busy[p]) begin
                        if (issued[p] < NTX && (issued[p] == 0 || $urandom_range(0, 2) != 0)) begin
                            t.we = 1'($urandom);
                            t.addr = 7'($urandom);
                            t.wdata = 8'($urandom);
                            req[p] = 1'b1; we[p] = t.we; addr[p] = t.addr; wdata[p] = t.wdata;
                            expq[p].push_back(t);
                            issued[p]++;
                            busy[p] = 1'b1;
                            scr[p] = 1'b0;
                        end else begin
                            req[p] = 1'b0;
                        end
                    end else if (!scr[p] && grant_out == ((p == 0) ? 2'b01 : 2'b10)
                                 && $urandom_range(0, 3) == 0) begin
                        req[p] = 1'($urandom);
                        we[p] = ~we[p];
                        addr[p] = ~addr[p];
                        wdata[p] = 8'($urandom);
                        scr[p] = 1'b1;
                    end
                end
            end
            chk(gi, "completed_in_budget", c < LIMIT, 1);
            repeat (4) @(negedge clk);
            chk(gi, "scoreboard_empty", expq[0].size() + expq[1].size(), 0);
            bdone[gi] = 1'b1;
        end

        initial begin : mon
            logic       lg, cur_p, end_we, in_acc;
            int         acc_len, end_cyc, mcyc;
            logic [7:0] prev_din;
            logic [1:0] pg;
            txn_t       cur, dummy;
            lg = 1'b1; cur_p = 1'b0; end_we = 1'b0; in_acc = 1'b0;
            acc_len = 0; end_cyc = -10; mcyc = 0; prev_din = 8'h00; pg = 2'b00;
            cur = '0;
            forever begin
                @(negedge clk);
                mcyc++;
                if (mon_en) begin
                    if (ack != 2'b00) begin
                        chk(gi, "ack_port", ack, in_acc ? (cur_p ? 2'b10 : 2'b01) : 2'b00);
                        if (in_acc) begin
                            chk(gi, "access_len", acc_len, AC);
                            chk(gi, "rdata", cur_p ? rdata[1] : rdata[0], cur.we ? 8'h00 : prev_din);
                            chk(gi, "other_rdata", cur_p ? rdata[0] : rdata[1], 0);
                            chk(gi, "done_bus", {we_out, drive_out, addr_out}, {2'b00, cur.addr});
                            dummy = expq[cur_p].pop_front();
                            lg = cur_p;
                            in_acc = 1'b0;
                            end_cyc = mcyc;
                            end_we = cur.we;
                        end
                    end else begin
                        chk(gi, "idle_rdata", {rdata[0], rdata[1]}, 0);
                        if (mcyc == end_cyc + 1)
                            chk(gi, "post_ack_bus", {grant_out, we_out, drive_out, addr_out, data_out}, 0);
                        if (pg == 2'b00 && grant_out != 2'b00) begin
                            cur_p = (samp_req == 2'b11) ? ~lg : samp_req[1];
                            chk(gi, "grant", grant_out, (samp_req == 2'b00) ? 2'b00 : (cur_p ? 2'b10 : 2'b01));
                            chk(gi, "turnaround_gap", (mcyc - end_cyc) >= (end_we ? 3 : 2), 1);
                            if (expq[cur_p].size() == 0) begin
                                chk(gi, "grant_without_txn", 0, 1);
                            end else begin
                                cur = expq[cur_p][0];
                                in_acc = 1'b1;
                                acc_len = 0;
                            end
                        end
                        if (in_acc && grant_out != 2'b00) begin
                            acc_len++;
                            chk(gi, "access_bus", {addr_out, we_out, drive_out, data_out},
                                {cur.addr, cur.we, cur.we, cur.we ? cur.wdata : 8'h00});
                        end
                    end
                end
                pg = grant_out;
                prev_din = data_in;
            end
        end
    end

    initial begin
        int t;
        t = 0;
        while (!(bdone[0] && bdone[1] && bdone[2]) && t < 6000) begin
            @(negedge clk);
            t++;
        end
        chk(-1, "all_instances_done", bdone[0] && bdone[1] && bdone[2], 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/minibyte_bus_arbiter.md
Name: minibyte_bus_arbiter

Overview:
- Shares the single external memory/IO bus between two requesters: port 0 is the minibyte CPU core and port 1 is the DFT/program-loader engine.
- Runs each granted access as a fixed-length bus cycle, captures read data and returns a one-cycle acknowledge.
- Inserts a turnaround cycle after writes so the bidirectional data pins never contend.
- Sits between the requesters and the top-level pins (address, data, WE, drive enable).

Parameters:
- ADDR_W, 7, address width on the pins and on each requester port.
- DATA_W, 8, data width.
- ACCESS_CYCLES, 2, bus cycles per access (legal range 1..15).

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_in  input  1  asynchronous, active-high reset.
- m0_req  input  1  CPU access request; held until m0_ack.
- m0_we  input  1  CPU write (1) / read (0).
- m0_addr  input  ADDR_W  CPU address.
- m0_wdata  input  DATA_W  CPU write data.
- m0_ack  output  1  one-cycle completion pulse to the CPU.
- m0_rdata  output  DATA_W  CPU read data; valid while m0_ack=1.
- m1_req, m1_we, m1_addr, m1_wdata, m1_ack, m1_rdata  same as port 0, for the loader.
- data_in  input  DATA_W  bus read data from the pins.
- addr_out  output  ADDR_W  bus address.
- data_out  output  DATA_W  bus write data.
- we_out  output  1  bus write strobe.
- drive_out  output  1  data pin output enable; 1 = drive data_out.
- grant_out  output  2  one-hot current owner, for debug; 00 = none.

Behaviour:
- Reset: every output is 0 while rst_in=1; state=IDLE; last_grant=1, so port 0 wins the first tie. Reset asserted mid-access aborts it with no ack; outputs go to 0 asynchronously.
- All outputs are registered. Requester inputs are sampled only in IDLE.
- FSM states: IDLE, ACCESS, DONE, TURN.
- IDLE:
  - No request -> stay in IDLE.
  - One request -> grant that port.
  - Both requesting -> grant the port not equal to last_grant (round-robin).
  - On grant: latch port, we, addr and wdata into internal registers; load counter=ACCESS_CYCLES-1; go to ACCESS.
- ACCESS:
  - addr_out = latched addr; grant_out = one-hot port.
  - Write: we_out=1, drive_out=1, data_out = latched wdata.
  - Read: we_out=0, drive_out=0, data_out=0.
  - Counter decrements each cycle. When the counter reaches 0, capture data_in into the read register (reads only) and go to DONE. ACCESS therefore lasts exactly ACCESS_CYCLES cycles.
- DONE (one cycle):
  - The granted port's mX_ack=1 and mX_rdata = captured data (0 for writes). The other port's ack and rdata stay 0.
  - we_out=0 and drive_out=0; addr_out holds its value.
  - last_grant updates to the granted port.
  - Next state: TURN if the access was a write, otherwise IDLE.
- TURN (one cycle, writes only): all bus outputs 0, grant_out=00; then IDLE.
- Latency, read: req first seen in IDLE at edge N -> ACCESS during cycles N+1..N+ACCESS_CYCLES -> ack during cycle N+ACCESS_CYCLES+1.
- Throughput: back-to-back reads from one port give one access per ACCESS_CYCLES+2 cycles; writes take one extra cycle for TURN.
- Request rules:
  - A requester may keep req high after ack to issue its next access; it is re-arbitrated in IDLE.
  - Dropping req mid-access has no effect; the access completes and ack still pulses.
  - Changes to addr/we/wdata after grant are ignored, since values are latched.
- Simultaneous events:
  - A new request from the other port during ACCESS or DONE waits for IDLE.
  - Under continuous contention, grants alternate 0,1,0,1 and neither port starves.
- The counter width is sized for ACCESS_CYCLES ≤ 15. A value of 1 gives a single ACCESS cycle; there is no wrap or underflow.

Test Plan:
- Reset: assert rst_in mid-ACCESS of a write -> we_out, drive_out, m0_ack and grant_out all 0 immediately; after release, no ack appears for the aborted access.
- Single read: m0 reads addr 0x15, bench drives data_in=0xA5, ACCESS_CYCLES=2 -> addr_out=0x15 for 2 cycles with drive_out=0; m0_ack=1 for exactly 1 cycle with m0_rdata=0xA5, three cycles after req was sampled.
- Single write: m1 writes 0x3C to 0x7F -> we_out=1, drive_out=1 and data_out=0x3C for 2 cycles; m1_ack pulses with m1_rdata=0x00; one TURN cycle with all bus outputs 0 before the next grant.
- Contention: both ports hold req for 4 accesses starting from reset -> grant order 0,1,0,1; each port gets exactly 2 acks; m0_ack and m1_ack are never high together.
- Mid-access changes: m0 drops req and changes m0_addr one cycle after grant -> addr_out keeps the latched value and m0_ack still pulses once.
- Parameter sweep: ACCESS_CYCLES=1 and 15 -> ACCESS lasts 1 and 15 cycles respectively; read data is captured from data_in on the final ACCESS cycle only (bench changes data_in on every other cycle to check this).
